reg_alu_seq: RTL and testbench

//   Parametrised register file with a fused ALU and a built-in phase sequencer.
//   One clock; the internal FSM generates the read, execute and write-back phases.

---
 rtl/reg_alu_seq.sv | 164 ++++++++++++++++
 tb/tb_reg_alu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_seq.sv
// Register file with a fused ALU and a RR -> EX -> WB phase sequencer behind a start/busy/done handshake.
// Define REG_ALU_DBG_EN to add the combinational dbg_addr/dbg_data register peek port.
module reg_alu_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        alu_op,
    input  logic [ADDR_W-1:0] r_addr_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              reg_write,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
`ifdef REG_ALU_DBG_EN
    output logic [3:0]        fr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`else
    output logic [3:0]        fr
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned MSB   = DATA_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RR   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   accept;

    logic [DATA_W-1:0] regs [DEPTH];

    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_a, cmd_b, cmd_w;
    logic              cmd_we, cmd_imm_sel;
    logic [DATA_W-1:0] cmd_imm;
    logic [DATA_W-1:0] op_a, op_b;

    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] alu_f;
    logic [3:0]        alu_fr;
    logic [DATA_W:0]   add_w, sub_w;
    logic              alu_cf, alu_of;
    logic              wb_en;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state: each phase lasts one cycle; start only counts in IDLE
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = S_RR;
            end
            S_RR:    state_nx = S_EX;
            S_EX:    state_nx = S_WB;
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Register-file reads, with address 0 hard-wired to zero when enabled
    always_comb begin
        rd_a = ((ZERO_REG != 1'b0) && (cmd_a == '0)) ? '0 : regs[cmd_a];
        rd_b = ((ZERO_REG != 1'b0) && (cmd_b == '0)) ? '0 : regs[cmd_b];
    end

    // ALU and flags on the latched operands
    always_comb begin
        alu_f  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        add_w  = {1'b0, op_a} + {1'b0, op_b};
        sub_w  = {1'b0, op_a} - {1'b0, op_b};
        case (cmd_op)
            4'd0: begin
                alu_f  = add_w[MSB:0];
                alu_cf = add_w[DATA_W];
                alu_of = (op_a[MSB] == op_b[MSB]) && (add_w[MSB] != op_a[MSB]);
            end
            4'd1: begin
                alu_f  = sub_w[MSB:0];
                alu_cf = sub_w[DATA_W];
                alu_of = (op_a[MSB] != op_b[MSB]) && (sub_w[MSB] != op_a[MSB]);
            end
            4'd2:    alu_f = op_a & op_b;
            4'd3:    alu_f = op_a | op_b;
            4'd4:    alu_f = op_a ^ op_b;
            4'd5:    alu_f = ~(op_a | op_b);
            4'd6:    alu_f = DATA_W'($signed(op_a) < $signed(op_b));
            4'd7:    alu_f = op_a << op_b[SH_W-1:0];
            default: alu_f = '0;
        endcase
        alu_fr = {(alu_f == '0), alu_cf, alu_of, alu_f[MSB]};
    end

    assign wb_en = (state == S_WB) && cmd_we && !((ZERO_REG != 1'b0) && (cmd_w == '0));

    // Command capture, operand/result latches, write-back and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_op      <= '0;
            cmd_a       <= '0;
            cmd_b       <= '0;
            cmd_w       <= '0;
            cmd_we      <= 1'b0;
            cmd_imm_sel <= 1'b0;
            cmd_imm     <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            fr          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state == S_WB);
            if (accept) begin
                cmd_op      <= alu_op;
                cmd_a       <= r_addr_a;
                cmd_b       <= r_addr_b;
                cmd_w       <= w_addr;
                cmd_we      <= reg_write;
                cmd_imm_sel <= imm_sel;
                cmd_imm     <= imm;
            end
            if (state == S_RR) begin
                op_a <= rd_a;
                op_b <= rd_b;
            end
            if ((state == S_EX) && !cmd_imm_sel) begin
                result <= alu_f;
                fr     <= alu_fr;
            end
            if (wb_en) regs[cmd_w] <= cmd_imm_sel ? cmd_imm : result;
        end
    end

`ifdef REG_ALU_DBG_EN
    // Display peek, independent of the sequencer
    assign dbg_data = ((ZERO_REG != 1'b0) && (dbg_addr == '0)) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// Directed, table-driven bench for reg_alu_seq (DATA_W=32, ADDR_W=5, ZERO_REG=1).
// Register contents are read back by running OR with reg[0]; the debug port is also checked when enabled.
module tb_reg_alu_seq;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                           NOR_ = 4'd5, SLT = 4'd6, SLL = 4'd7;

    logic        clk = 1'b0;
    logic        rst, start, reg_write, imm_sel;
    logic [3:0]  alu_op;
    logic [4:0]  r_addr_a, r_addr_b, w_addr;
    logic [31:0] imm;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  fr;
`ifdef REG_ALU_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    reg_alu_seq #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .w_addr(w_addr),
        .reg_write(reg_write), .imm_sel(imm_sel), .imm(imm),
        .busy(busy), .done(done), .result(result),
`ifdef REG_ALU_DBG_EN
        .fr(fr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`else
        .fr(fr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  a, b, w;
        logic        we, isel;
        logic [31:0] imm;
        logic [31:0] exp_res;
        logic [3:0]  exp_fr;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t v(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] w, input logic we, input logic isel,
                               input logic [31:0] im, input logic [31:0] er, input logic [3:0] ef);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.w = w; t.we = we; t.isel = isel;
        t.imm = im; t.exp_res = er; t.exp_fr = ef;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] w, input logic we, input logic isel, input logic [31:0] im);
        alu_op = op; r_addr_a = a; r_addr_b = b; w_addr = w;
        reg_write = we; imm_sel = isel; imm = im;
    endtask

    // Called one cycle after the accepting edge; returns in the done cycle
    task automatic wait_done(input string name);
        int n = 1;
        while (!done && n < 10) begin
            check({name, " busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd4);
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] w, input logic we, input logic isel, input logic [31:0] im,
                           input string name);
        @(negedge clk);
        drive(op, a, b, w, we, isel, im);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(4'hF, 5'h1F, 5'h1F, 5'h1F, 1'b1, 1'b1, 32'hDEAD_BEEF);
        wait_done(name);
    endtask

    task automatic readback(input logic [4:0] r, input logic [31:0] exp, input string name);
        run_cmd(OR_, r, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, name);
        check(name, result, exp);
    endtask

    initial begin
        tbl[0]  = v(4'd0, 0, 0, 1,  1, 1, 32'h0000_000A, 32'h0000_0000, 4'h0);
        tbl[1]  = v(4'd0, 0, 0, 2,  1, 1, 32'h0000_000A, 32'h0000_0000, 4'h0);
        tbl[2]  = v(SUB,  1, 2, 3,  1, 0, 32'h0,         32'h0000_0000, 4'h8);
        tbl[3]  = v(OR_,  3, 0, 0,  0, 0, 32'h0,         32'h0000_0000, 4'h8);
        tbl[4]  = v(4'd0, 0, 0, 4,  1, 1, 32'h7FFF_FFFF, 32'h0000_0000, 4'h8);
        tbl[5]  = v(4'd0, 0, 0, 5,  1, 1, 32'h0000_0001, 32'h0000_0000, 4'h8);
        tbl[6]  = v(ADD,  4, 5, 6,  1, 0, 32'h0,         32'h8000_0000, 4'h3);
        tbl[7]  = v(OR_,  6, 0, 0,  0, 0, 32'h0,         32'h8000_0000, 4'h1);
        tbl[8]  = v(4'd0, 0, 0, 7,  1, 1, 32'hFFFF_FFFF, 32'h8000_0000, 4'h1);
        tbl[9]  = v(ADD,  7, 5, 8,  1, 0, 32'h0,         32'h0000_0000, 4'hC);
        tbl[10] = v(SUB,  5, 4, 0,  0, 0, 32'h0,         32'h8000_0002, 4'h5);
        tbl[11] = v(SUB,  4, 7, 0,  0, 0, 32'h0,         32'h8000_0000, 4'h7);
        tbl[12] = v(AND_, 7, 1, 0,  0, 0, 32'h0,         32'h0000_000A, 4'h0);
        tbl[13] = v(OR_,  1, 4, 0,  0, 0, 32'h0,         32'h7FFF_FFFF, 4'h0);
        tbl[14] = v(XOR_, 7, 4, 0,  0, 0, 32'h0,         32'h8000_0000, 4'h1);
        tbl[15] = v(NOR_, 1, 0, 0,  0, 0, 32'h0,         32'hFFFF_FFF5, 4'h1);
        tbl[16] = v(SLT,  7, 5, 0,  0, 0, 32'h0,         32'h0000_0001, 4'h0);
        tbl[17] = v(SLT,  5, 7, 0,  0, 0, 32'h0,         32'h0000_0000, 4'h8);
        tbl[18] = v(4'd0, 0, 0, 9,  1, 1, 32'h0000_0024, 32'h0000_0000, 4'h8);
        tbl[19] = v(SLL,  1, 9, 0,  0, 0, 32'h0,         32'h0000_00A0, 4'h0);
        tbl[20] = v(4'd9, 7, 7, 0,  0, 0, 32'h0,         32'h0000_0000, 4'h8);
        tbl[21] = v(4'd0, 0, 0, 0,  1, 1, 32'h0000_0055, 32'h0000_0000, 4'h8);
        tbl[22] = v(OR_,  0, 1, 0,  0, 0, 32'h0,         32'h0000_000A, 4'h0);
        tbl[23] = v(ADD,  1, 1, 1,  1, 0, 32'h0,         32'h0000_0014, 4'h0);
        tbl[24] = v(OR_,  1, 0, 0,  0, 0, 32'h0,         32'h0000_0014, 4'h0);
        tbl[25] = v(4'd0, 0, 0, 10, 0, 1, 32'h0000_0099, 32'h0000_0014, 4'h0);
        tbl[26] = v(OR_, 10, 0, 0,  0, 0, 32'h0,         32'h0000_0000, 4'h8);

        start = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
`ifdef REG_ALU_DBG_EN
        dbg_addr = '0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset fr", 32'(fr), 32'd0);
`ifdef REG_ALU_DBG_EN
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("reset dbg r%0d", i), dbg_data, 32'd0);
        end
`endif

        for (int i = 0; i < 27; i++) begin
            run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].we, tbl[i].isel, tbl[i].imm,
                    $sformatf("vec%0d", i));
            check($sformatf("vec%0d result", i), result, tbl[i].exp_res);
            check($sformatf("vec%0d fr", i), 32'(fr), 32'(tbl[i].exp_fr));
        end
`ifdef REG_ALU_DBG_EN
        dbg_addr = 5'd1; #1;
        check("dbg r1", dbg_data, 32'h14);
        dbg_addr = 5'd0; #1;
        check("dbg r0", dbg_data, 32'h0);
`endif

        // start held high through the whole command: only one runs, later inputs ignored
        @(negedge clk);
        drive(4'd0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'h11);
        start = 1'b1;
        @(negedge clk);
        drive(4'd0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 32'h22);
        repeat (3) begin
            check("held busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        check("held done", 32'(done), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("held no second done", 32'(done), 32'd0);
            check("held no second busy", 32'(busy), 32'd0);
        end
        readback(5'd11, 32'h11, "held r11");
        readback(5'd12, 32'h0, "held r12 untouched");

        // start in the done cycle, reading the register just written
        run_cmd(4'd0, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 32'h5A, "b2b write");
        drive(OR_, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b read");
        check("b2b read result", result, 32'h5A);

        // reset asserted during EX abandons the command
        @(negedge clk);
        drive(ADD, 5'd1, 5'd1, 5'd14, 1'b1, 1'b0, 32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid done", 32'(done), 32'd0);
        check("rst mid result", result, 32'd0);
        @(negedge clk);
        check("rst mid no late done", 32'(done), 32'd0);
        readback(5'd14, 32'h0, "rst mid r14");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
